mux4_rr_scheduler: RTL and testbench

MUX4_RR_SCHEDULER -- requirements
Module: mux4_rr_scheduler

---
 rtl/mux4_rr_scheduler.sv | 122 ++++++++++++
 tb/tb_mux4_rr_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_scheduler.sv
// Round-robin 4:1 scheduler with a bounded hold time and a registered shared data mux.
// Optional macro ARB_LOCK_EN adds a lock input that holds the grant past timeout.
module mux4_rr_scheduler #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [1:0] d0,
  input  logic [1:0] d1,
  input  logic [1:0] d2,
  input  logic [1:0] d3,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic [1:0] q,
  output logic       valid
);

  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] q_q, q_d;
  logic       valid_q, valid_d;

  logic       timeout;
  logic       release_grant;
  logic       new_grant;
  logic [1:0] arb_ptr;
  logic [1:0] winner;
  logic [1:0] mux_out;

  // First set request bit searching upward from p, modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      q_q     <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    timeout = (cnt_q == HoldLast);
`ifdef ARB_LOCK_EN
    // Lock only defers a timeout; a dropped request still releases.
    timeout = timeout && !(lock && req[sel_q]);
`endif
    release_grant = (state_q == StGrant) && (!req[sel_q] || timeout);
    arb_ptr       = release_grant ? sel_q + 2'd1 : ptr_q;
    winner        = pick(req, arb_ptr);
    state_d       = state_q;
    unique case (state_q)
      StIdle:  if (|req) state_d = StGrant;
      StGrant: if (release_grant && !(|req)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    unique case (sel_q)
      2'd0:    mux_out = d0;
      2'd1:    mux_out = d1;
      2'd2:    mux_out = d2;
      default: mux_out = d3;
    endcase
    new_grant = (state_d == StGrant) && ((state_q == StIdle) || release_grant);
    ptr_d     = release_grant ? arb_ptr : ptr_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    valid_d   = 1'b0;
    if (state_q == StGrant) begin
      q_d     = mux_out;
      valid_d = 1'b1;
    end
    if (new_grant) begin
      grant_d = 4'b0001 << winner;
      sel_d   = winner;
      cnt_d   = 8'd0;
    end else if (state_d == StIdle) begin
      grant_d = 4'b0000;
    end else if (cnt_q != HoldLast) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign q     = q_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Directed bench for mux4_rr_scheduler: vector table on a HOLD_CYCLES=4 instance plus
// rotation and lock sequences on HOLD_CYCLES=2 and HOLD_CYCLES=1 instances.
module tb_mux4_rr_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [1:0] d0, d1, d2, d3;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif

  logic [3:0] grant4, grant2, grant1;
  logic [1:0] sel4, sel2, sel1;
  logic [1:0] q4, q2, q1;
  logic       valid4, valid2, valid1;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  mux4_rr_scheduler #(.HOLD_CYCLES(4)) dut4 (
    .clock(clock), .reset(reset), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(grant4), .sel(sel4), .q(q4), .valid(valid4)
  );

  mux4_rr_scheduler #(.HOLD_CYCLES(2)) dut2 (
    .clock(clock), .reset(reset), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(grant2), .sel(sel2), .q(q2), .valid(valid2)
  );

  mux4_rr_scheduler #(.HOLD_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(grant1), .sel(sel1), .q(q1), .valid(valid1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [7:0] d;      // {d3, d2, d1, d0}
    logic [3:0] grant;
    logic [1:0] sel;
    logic [1:0] q;
    logic       valid;
  } vec_t;

  localparam int NumVec = 25;
  vec_t tbl[NumVec];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [3:0] rot2[9];
  logic [3:0] rot1[9];
  logic [3:0] lock_seq[7];

  initial begin
    // HOLD_CYCLES=4 vectors: outputs expected right after the edge that samples the inputs.
    tbl[0]  = '{1'b1, 4'b0000, 8'h39, 4'b0000, 2'd0, 2'b00, 1'b0};
    tbl[1]  = '{1'b0, 4'b0100, 8'h39, 4'b0100, 2'd2, 2'b00, 1'b0};
    tbl[2]  = '{1'b0, 4'b0100, 8'h39, 4'b0100, 2'd2, 2'b11, 1'b1};
    tbl[3]  = '{1'b0, 4'b0100, 8'h39, 4'b0100, 2'd2, 2'b11, 1'b1};
    tbl[4]  = '{1'b0, 4'b0100, 8'h39, 4'b0100, 2'd2, 2'b11, 1'b1};
    tbl[5]  = '{1'b0, 4'b0100, 8'h39, 4'b0100, 2'd2, 2'b11, 1'b1};
    tbl[6]  = '{1'b0, 4'b0010, 8'h39, 4'b0010, 2'd1, 2'b11, 1'b1};
    tbl[7]  = '{1'b0, 4'b1001, 8'h39, 4'b1000, 2'd3, 2'b10, 1'b1};
    tbl[8]  = '{1'b0, 4'b1001, 8'h79, 4'b1000, 2'd3, 2'b01, 1'b1};
    tbl[9]  = '{1'b0, 4'b0000, 8'h79, 4'b0000, 2'd3, 2'b01, 1'b1};
    tbl[10] = '{1'b0, 4'b0000, 8'h79, 4'b0000, 2'd3, 2'b01, 1'b0};
    tbl[11] = '{1'b0, 4'b0010, 8'h79, 4'b0010, 2'd1, 2'b01, 1'b0};
    tbl[12] = '{1'b0, 4'b0010, 8'h79, 4'b0010, 2'd1, 2'b10, 1'b1};
    tbl[13] = '{1'b0, 4'b0010, 8'h79, 4'b0010, 2'd1, 2'b10, 1'b1};
    tbl[14] = '{1'b1, 4'b0010, 8'h79, 4'b0000, 2'd0, 2'b00, 1'b0};
    tbl[15] = '{1'b0, 4'b0010, 8'h79, 4'b0010, 2'd1, 2'b00, 1'b0};
    tbl[16] = '{1'b0, 4'b0010, 8'h79, 4'b0010, 2'd1, 2'b10, 1'b1};
    tbl[17] = '{1'b0, 4'b0010, 8'h79, 4'b0010, 2'd1, 2'b10, 1'b1};
    tbl[18] = '{1'b0, 4'b0010, 8'h79, 4'b0010, 2'd1, 2'b10, 1'b1};
    tbl[19] = '{1'b1, 4'b0110, 8'h79, 4'b0000, 2'd0, 2'b00, 1'b0};
    tbl[20] = '{1'b0, 4'b0110, 8'h79, 4'b0010, 2'd1, 2'b00, 1'b0};
    tbl[21] = '{1'b0, 4'b0110, 8'h79, 4'b0010, 2'd1, 2'b10, 1'b1};
    tbl[22] = '{1'b0, 4'b0110, 8'h79, 4'b0010, 2'd1, 2'b10, 1'b1};
    tbl[23] = '{1'b0, 4'b0110, 8'h79, 4'b0010, 2'd1, 2'b10, 1'b1};
    tbl[24] = '{1'b0, 4'b0110, 8'h79, 4'b0100, 2'd2, 2'b10, 1'b1};

    rot2 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    rot1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`ifdef ARB_LOCK_EN
    lock_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    lock = 1'b0;
`else
    lock_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0010};
`endif

    reset = 1'b1;
    req   = 4'b0000;
    {d3, d2, d1, d0} = 8'h39;
    #2;

    for (int i = 0; i < NumVec; i++) begin
      reset = tbl[i].rst;
      req   = tbl[i].req;
      {d3, d2, d1, d0} = tbl[i].d;
      step();
      check($sformatf("vec%0d_grant", i), {4'b0, grant4}, {4'b0, tbl[i].grant});
      check($sformatf("vec%0d_sel", i), {6'b0, sel4}, {6'b0, tbl[i].sel});
      check($sformatf("vec%0d_q", i), {6'b0, q4}, {6'b0, tbl[i].q});
      check($sformatf("vec%0d_valid", i), {7'b0, valid4}, {7'b0, tbl[i].valid});
    end

    // All four requesting: HOLD_CYCLES=2 pairs, HOLD_CYCLES=1 single-cycle rotation.
    reset = 1'b1;
    req   = 4'b0000;
    step();
    check("rst_grant2", {4'b0, grant2}, 8'h00);
    check("rst_valid2", {7'b0, valid2}, 8'h00);
    reset = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("rot2_%0d", i), {4'b0, grant2}, {4'b0, rot2[i]});
      check($sformatf("rot1_%0d", i), {4'b0, grant1}, {4'b0, rot1[i]});
      if (i > 0) check($sformatf("rot2_valid_%0d", i), {7'b0, valid2}, 8'h01);
    end

    // Lock held for six grant cycles on HOLD_CYCLES=2, then dropped.
    reset = 1'b1;
    req   = 4'b0000;
    step();
    reset = 1'b0;
    req   = 4'b0011;
`ifdef ARB_LOCK_EN
    lock  = 1'b1;
`endif
    for (int i = 0; i < 7; i++) begin
`ifdef ARB_LOCK_EN
      if (i == 6) lock = 1'b0;
`endif
      step();
      check($sformatf("lock_%0d", i), {4'b0, grant2}, {4'b0, lock_seq[i]});
    end

    // Drop all requests at a release: idle with sel retained, valid falls one edge later.
    req = 4'b0000;
    step();
    check("idle_grant", {4'b0, grant2}, 8'h00);
    check("idle_sel", {6'b0, sel2}, 8'h01);
    check("idle_valid_hi", {7'b0, valid2}, 8'h01);
    step();
    check("idle_valid_lo", {7'b0, valid2}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
